axil_wide_ram_port: RTL and testbench

- AXI4-Lite slave that gives 32-bit register-style access to a wide, parametrised dual-port RAM.
- Port A is the write port, with per-byte write enables. Port B is the read port, with a configurable fixed latency.
- Lane steering is by address; no read-modify-write is needed.
- Sits between the host AXI4-Lite interconnect and wide data-path RAMs such as packet and sample buffers. It implements the AXI4-Lite handshakes itself.

---
 rtl/axil_ram_pkg.sv | 37 +++
 rtl/axil_ram_lane.sv | 32 +++
 rtl/axil_wide_ram_port.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_axil_wide_ram_port.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ram_pkg.sv
// Shared response codes, FSM state encodings and sizing helpers for the
// AXI4-Lite wide RAM port.
package axil_ram_pkg;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;

  typedef enum logic [1:0] {
    WIdle,
    WExec,
    WResp
  } wr_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RIssue,
    RWait,
    RResp
  } rd_state_e;

  // Number of 32-bit lanes in a RAM word.
  function automatic int unsigned lane_count(input int unsigned dw);
    return dw / 32;
  endfunction

  // Ceiling log2; returns 0 for an input of 1.
  function automatic int unsigned log2c(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_ram_lane.sv
// Lane steering between a 32-bit AXI word and a wide RAM word: byte-enable
// shift and data replication on insert, 32-bit slice select on extract.
module axil_ram_lane
  import axil_ram_pkg::*;
#(
  parameter int unsigned RAM_DW = 128
) (
  input  logic [((log2c(lane_count(RAM_DW)) > 0) ? log2c(lane_count(RAM_DW)) : 1)-1:0] wr_lane_i,
  input  logic [3:0]                                                                 wstrb_i,
  input  logic [31:0]                                                                wdata_i,
  output logic [RAM_DW/8-1:0]                                                        wbe_o,
  output logic [RAM_DW-1:0]                                                          wdata_o,
  input  logic [((log2c(lane_count(RAM_DW)) > 0) ? log2c(lane_count(RAM_DW)) : 1)-1:0] rd_lane_i,
  input  logic [RAM_DW-1:0]                                                          rdata_i,
  output logic [31:0]                                                                rdata_o
);

  localparam int unsigned Lanes = lane_count(RAM_DW);
  localparam int unsigned BeW   = RAM_DW / 8;

  logic [BeW-1:0] be_base;

  always_comb begin
    be_base      = '0;
    be_base[3:0] = wstrb_i;
    // Each lane owns four byte enables, so the shift is lane * 4.
    wbe_o        = be_base << {wr_lane_i, 2'b00};
    wdata_o      = {Lanes{wdata_i}};
    rdata_o      = rdata_i[{rd_lane_i, 5'b00000} +: 32];
  end

endmodule

// File: rtl/axil_wide_ram_port.sv
// AXI4-Lite slave giving 32-bit access to a wide dual-port RAM: port A
// writes with byte enables, port B reads with a fixed latency.
module axil_wide_ram_port
  import axil_ram_pkg::*;
#(
  parameter int unsigned RAM_DW     = 128,
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [31:0]         S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic                ram_we,
  output logic [RAM_DW/8-1:0] ram_wbe,
  output logic [RAM_AW-1:0]   ram_waddr,
  output logic [RAM_DW-1:0]   ram_wdata,
  output logic                ram_re,
  output logic [RAM_AW-1:0]   ram_raddr,
  input  logic [RAM_DW-1:0]   ram_rdata
);

  localparam int unsigned Lanes  = lane_count(RAM_DW);
  localparam int unsigned LB     = log2c(Lanes);
  localparam int unsigned LaneW  = (LB > 0) ? LB : 1;
  localparam int unsigned BeW    = RAM_DW / 8;
  localparam int unsigned TopBit = 2 + LB + RAM_AW;
  localparam logic [2:0]  LatCnt = 3'(RD_LATENCY);

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >> TopBit) == 32'd0;
  endfunction

  function automatic logic [LaneW-1:0] lane_of(input logic [31:0] a);
    return (LB == 0) ? '0 : a[2 +: LaneW];
  endfunction

  function automatic logic [RAM_AW-1:0] word_of(input logic [31:0] a);
    return a[2 + LB +: RAM_AW];
  endfunction

  // ---------------------------------------------------------------- write
  wr_state_e         w_state_q, w_state_d;
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]       awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              ram_we_q, ram_we_d;
  logic [BeW-1:0]    ram_wbe_q, ram_wbe_d;
  logic [RAM_AW-1:0] ram_waddr_q, ram_waddr_d;
  logic [RAM_DW-1:0] ram_wdata_q, ram_wdata_d;

  logic              aw_hs, w_hs;
  logic [31:0]       aw_addr_cur, wdata_cur;
  logic [3:0]        wstrb_cur;
  logic [LaneW-1:0]  aw_lane;
  logic [BeW-1:0]    wr_wbe;
  logic [RAM_DW-1:0] wr_wdata;
  logic [BeW-1:0]    unused_rd_wbe;
  logic [RAM_DW-1:0] unused_rd_wdata;
  logic [31:0]       unused_wr_rdata;

  assign aw_hs       = S_AXI_AWVALID & awready_q;
  assign w_hs        = S_AXI_WVALID & wready_q;
  // A channel captured this very cycle is not in its register yet.
  assign aw_addr_cur = aw_hs ? S_AXI_AWADDR : awaddr_q;
  assign wdata_cur   = w_hs ? S_AXI_WDATA : wdata_q;
  assign wstrb_cur   = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign aw_lane     = lane_of(aw_addr_cur);

  axil_ram_lane #(
    .RAM_DW(RAM_DW)
  ) u_lane_wr (
    .wr_lane_i(aw_lane),
    .wstrb_i  (wstrb_cur),
    .wdata_i  (wdata_cur),
    .wbe_o    (wr_wbe),
    .wdata_o  (wr_wdata),
    .rd_lane_i('0),
    .rdata_i  ('0),
    .rdata_o  (unused_wr_rdata)
  );

  always_comb begin
    w_state_d   = w_state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    ram_we_d    = 1'b0;
    ram_wbe_d   = ram_wbe_q;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = S_AXI_WDATA;
          wstrb_d  = S_AXI_WSTRB;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = WExec;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (addr_ok(aw_addr_cur) && (wstrb_cur != 4'd0)) begin
            ram_we_d    = 1'b1;
            ram_wbe_d   = wr_wbe;
            ram_waddr_d = word_of(aw_addr_cur);
            ram_wdata_d = wr_wdata;
          end
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      WExec: begin
        bvalid_d  = 1'b1;
        bresp_d   = addr_ok(awaddr_q) ? RespOkay : RespDecErr;
        w_state_d = WResp;
      end
      WResp: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = RespOkay;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q   <= WIdle;
      aw_held_q   <= 1'b0;
      w_held_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      ram_we_q    <= 1'b0;
      ram_wbe_q   <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      aw_held_q   <= aw_held_d;
      w_held_q    <= w_held_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      ram_we_q    <= ram_we_d;
      ram_wbe_q   <= ram_wbe_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // ----------------------------------------------------------------- read
  rd_state_e         r_state_q, r_state_d;
  logic              arready_q, arready_d;
  logic [LaneW-1:0]  ar_lane_q, ar_lane_d;
  logic              ram_re_q, ram_re_d;
  logic [RAM_AW-1:0] ram_raddr_q, ram_raddr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              ar_hs;
  logic [31:0]       rd_slice;

  assign ar_hs = S_AXI_ARVALID & arready_q;

  axil_ram_lane #(
    .RAM_DW(RAM_DW)
  ) u_lane_rd (
    .wr_lane_i('0),
    .wstrb_i  ('0),
    .wdata_i  ('0),
    .wbe_o    (unused_rd_wbe),
    .wdata_o  (unused_rd_wdata),
    .rd_lane_i(ar_lane_q),
    .rdata_i  (ram_rdata),
    .rdata_o  (rd_slice)
  );

  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    ar_lane_d   = ar_lane_q;
    ram_re_d    = 1'b0;
    ram_raddr_d = ram_raddr_q;
    cnt_d       = cnt_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;

    unique case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          ar_lane_d = lane_of(S_AXI_ARADDR);
          if (addr_ok(S_AXI_ARADDR)) begin
            ram_re_d    = 1'b1;
            ram_raddr_d = word_of(S_AXI_ARADDR);
            r_state_d   = RIssue;
          end else begin
            rvalid_d  = 1'b1;
            rdata_d   = '0;
            rresp_d   = RespDecErr;
            r_state_d = RResp;
          end
        end
      end
      RIssue: begin
        cnt_d     = LatCnt;
        r_state_d = RWait;
      end
      RWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          rdata_d   = rd_slice;
          rresp_d   = RespOkay;
          rvalid_d  = 1'b1;
          r_state_d = RResp;
        end
      end
      RResp: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q   <= RIdle;
      arready_q   <= 1'b0;
      ar_lane_q   <= '0;
      ram_re_q    <= 1'b0;
      ram_raddr_q <= '0;
      cnt_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= RespOkay;
    end else begin
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      ar_lane_q   <= ar_lane_d;
      ram_re_q    <= ram_re_d;
      ram_raddr_q <= ram_raddr_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ram_we        = ram_we_q;
  assign ram_wbe       = ram_wbe_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_re        = ram_re_q;
  assign ram_raddr     = ram_raddr_q;

endmodule

// File: tb/tb_axil_wide_ram_port.sv
// Bench for axil_wide_ram_port: directed cases then random traffic, checked
// against a flat 32-bit register-map model and a latency-exact RAM model.
module tb_axil_wide_ram_port;

  logic          clk;
  logic          reset;
  logic [31:0]   S_AXI_AWADDR;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [31:0]   S_AXI_ARADDR;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;
  logic          ram_we;
  logic [15:0]   ram_wbe;
  logic [9:0]    ram_waddr;
  logic [127:0]  ram_wdata;
  logic          ram_re;
  logic [9:0]    ram_raddr;
  logic [127:0]  ram_rdata;

  int checks = 0;
  int errors = 0;

  axil_wide_ram_port #(
    .RAM_DW    (128),
    .RAM_AW    (10),
    .RD_LATENCY(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .ram_we       (ram_we),
    .ram_wbe      (ram_wbe),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pat(input int unsigned idx);
    return 32'hA5A5_0000 ^ (idx * 32'h9E37_79B1);
  endfunction

  // RAM with exact two-cycle read latency; outside the valid slot it drives noise.
  logic [127:0] mem [1024];
  logic [127:0] d0, d1, garbage;
  logic [1:0]   v_pipe;
  bit           mem_init = 1'b0;
  int           we_cnt = 0;
  int           re_cnt = 0;
  logic [15:0]  last_wbe;
  logic [9:0]   last_waddr;
  logic [127:0] last_wdata;
  logic [9:0]   last_raddr;

  always @(posedge clk) begin
    if (reset) begin
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++)
          for (int l = 0; l < 4; l++) mem[i][32*l +: 32] <= pat(i * 4 + l);
        mem_init <= 1'b1;
      end
      v_pipe <= 2'b00;
    end else begin
      v_pipe  <= {v_pipe[0], ram_re};
      d0      <= mem[ram_raddr];
      d1      <= d0;
      garbage <= {$urandom, $urandom, $urandom, $urandom};
      if (ram_we) begin
        we_cnt     <= we_cnt + 1;
        last_wbe   <= ram_wbe;
        last_waddr <= ram_waddr;
        last_wdata <= ram_wdata;
        for (int b = 0; b < 16; b++)
          if (ram_wbe[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (ram_re) begin
        re_cnt     <= re_cnt + 1;
        last_raddr <= ram_raddr;
      end
    end
  end

  assign ram_rdata = v_pipe[1] ? d1 : garbage;

  // Reference: flat array of 32-bit registers, one per 4-byte AXI address.
  logic [31:0] model [4096];

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    if (addr < 32'h4000)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[13:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
                     S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID, ram_we, ram_wbe, ram_waddr,
                     ram_wdata, ram_re, ram_raddr}), 256'(0));
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int bdelay);
    int          aw_start, w_start, n, k, we0;
    bit          aw_done, w_done, aw_fire, w_fire, inr, exp_we;
    logic [1:0]  exp_resp;
    logic [15:0] exp_wbe;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    inr      = (addr < 32'h4000);
    exp_we   = inr && (strb != 4'd0);
    exp_resp = inr ? 2'd0 : 2'd3;
    exp_wbe  = {12'd0, strb} << {addr[3:2], 2'b00};
    we0      = we_cnt;
    aw_done  = 1'b0;
    w_done   = 1'b0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      S_AXI_AWVALID = !aw_done && (n >= aw_start);
      S_AXI_WVALID  = !w_done && (n >= w_start);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("aw_w_accepted", 256'({aw_done, w_done}), 256'(2'b11));
    k = 0;
    while (!S_AXI_BVALID && k < 10) begin
      tick();
      k++;
    end
    check("b_latency", 256'(k), 256'(1));
    check("we_pulses", 256'(we_cnt - we0), 256'(exp_we ? 1 : 0));
    if (exp_we) begin
      check("ram_wbe", 256'(last_wbe), 256'(exp_wbe));
      check("ram_waddr", 256'(last_waddr), 256'(addr[13:4]));
      check("ram_wdata", 256'(last_wdata), 256'({4{data}}));
    end
    check("bresp", 256'(S_AXI_BRESP), 256'(exp_resp));
    for (int d = 0; d < bdelay; d++) begin
      tick();
      check("b_hold", 256'({S_AXI_BVALID, S_AXI_BRESP}), 256'({1'b1, exp_resp}));
      check("aw_w_busy", 256'({S_AXI_AWREADY, S_AXI_WREADY}), 256'(0));
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("b_done", 256'(S_AXI_BVALID), 256'(0));
    model_write(addr, data, strb);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rdelay);
    int          n, k, re0;
    bit          inr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    inr      = (addr < 32'h4000);
    exp_data = inr ? model[addr[13:2]] : 32'h0;
    exp_resp = inr ? 2'd0 : 2'd3;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin
      tick();
      n++;
    end
    check("ar_ready", 256'(S_AXI_ARREADY), 256'(1));
    re0 = re_cnt;
    tick();
    S_AXI_ARVALID = 1'b0;
    k = 1;
    while (!S_AXI_RVALID && k < 20) begin
      tick();
      k++;
    end
    check("r_latency", 256'(k), 256'(inr ? 4 : 1));
    check("re_pulses", 256'(re_cnt - re0), 256'(inr ? 1 : 0));
    if (inr) check("ram_raddr", 256'(last_raddr), 256'(addr[13:4]));
    check("rdata", 256'(S_AXI_RDATA), 256'(exp_data));
    check("rresp", 256'(S_AXI_RRESP), 256'(exp_resp));
    for (int d = 0; d < rdelay; d++) begin
      tick();
      check("r_hold", 256'({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}),
            256'({1'b1, exp_resp, exp_data}));
      check("ar_busy", 256'(S_AXI_ARREADY), 256'(0));
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("r_done", 256'(S_AXI_RVALID), 256'(0));
  endtask

  initial begin
    logic [31:0] a, last_addr;
    S_AXI_AWADDR  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    for (int i = 0; i < 4096; i++) model[i] = pat(i);

    reset = 1'b0;
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset_outputs");
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("idle_ready", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 256'(3'b111));

    // Same-cycle AW/W, lane 1 of word 1.
    do_write(32'h14, 32'hDEADBEEF, 4'hF, 0, 0);
    // W three cycles ahead of AW, lane 2 of word 2, low half only.
    do_write(32'h28, 32'h12345678, 4'h3, 3, 0);
    do_read(32'h28, 0);
    // AW ahead of W.
    do_write(32'h3C, 32'h0F0F_AA55, 4'h9, -2, 0);
    do_read(32'h3C, 0);
    do_write(32'h14, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(32'h14, 0);
    do_read(32'h10, 0);
    // Zero strobe: okay response, RAM untouched.
    do_write(32'h20, 32'h1111_2222, 4'h0, 0, 0);
    do_read(32'h20, 0);
    // Out-of-range accesses.
    do_read(32'h4000, 0);
    do_write(32'h4000, 32'h5555_AAAA, 4'hF, 0, 0);
    do_read(32'h8000_0000, 0);
    do_write(32'hFFFF_FFFC, 32'h1, 4'hF, 1, 0);
    // Last in-range word and lane.
    do_write(32'h3FFC, 32'h7777_8888, 4'hF, 0, 0);
    do_read(32'h3FFC, 0);
    // Back-pressure on both response channels.
    do_write(32'h40, 32'hABCD_0123, 4'hF, 0, 5);
    do_read(32'h40, 5);
    do_read(32'h4004, 5);

    // Reset with write in response phase and read waiting on the RAM.
    S_AXI_AWADDR  = 32'h30;
    S_AXI_WDATA   = 32'h0BADCAFE;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    tick();
    model_write(32'h30, 32'h0BADCAFE, 4'hF);
    check("pre_reset_bvalid", 256'(S_AXI_BVALID), 256'(1));
    S_AXI_ARADDR  = 32'h30;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    tick();
    reset = 1'b1;
    #2 check_outputs_zero("midflight_reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_reset_ready", 256'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}),
          256'(3'b111));
    for (int i = 0; i < 4; i++) begin
      check("no_stale_resp", 256'({S_AXI_BVALID, S_AXI_RVALID}), 256'(0));
      tick();
    end
    do_read(32'h30, 0);

    // Random traffic.
    last_addr = 32'h14;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0)
        a = (32'h4000 << $urandom_range(0, 17)) | ($urandom & 32'h3FFF);
      else if ($urandom_range(0, 1) == 1)
        a = last_addr;
      else
        a = $urandom & 32'h3FFF;
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                 $urandom_range(0, 3));
        last_addr = a;
      end else begin
        do_read(a, $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
